// File: rtl/load_store_unit.sv
// Load/store unit sitting between a pipeline memory stage and a single-port
// data memory. Handles byte/halfword/word accesses, sub-word stores by
// read-modify-write, alignment checking and a bounded wait on mem_ready.
module load_store_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        lsu_stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        lsu_error,
    output logic [31:0] err_addr,
    output logic [31:0] A,
    output logic [31:0] WD,
    output logic        WE,
    input  logic [31:0] RD,
    input  logic        mem_ready,
    input  logic        mem_error
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          write_q, write_d;
    logic          unsigned_q, unsigned_d;
    logic          err_q, err_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   wd_q, wd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   load_data_q, load_data_d;
    logic [31:0]   err_addr_q, err_addr_d;
    logic          wait_expired;

    // Illegal size code, or an access not aligned to its own size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = lane[0];
            SIZE_W:  bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] rd, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (size)
            SIZE_B:  r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SIZE_H:  r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    // Overlay the store data onto the addressed lane of the word read back.
    function automatic logic [31:0] merge_store(input logic [31:0] rd, input logic [1:0] lane,
                                                input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] m;
        m = rd;
        case (size)
            SIZE_B: begin
                case (lane)
                    2'd0:    m[7:0]   = wdata[7:0];
                    2'd1:    m[15:8]  = wdata[7:0];
                    2'd2:    m[23:16] = wdata[7:0];
                    default: m[31:24] = wdata[7:0];
                endcase
            end
            SIZE_H: begin
                if (lane[1]) m[31:16] = wdata[15:0];
                else         m[15:0]  = wdata[15:0];
            end
            default: m = wdata;
        endcase
        return m;
    endfunction

    // A wait gives up once the counter would reach TIMEOUT-1; mem_ready wins a tie.
    assign wait_expired = !mem_ready && (cnt_q == CW'(TIMEOUT - 2));

    // Next-state, request latch and memory-side register updates.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned (no latches).
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        write_d     = write_q;
        unsigned_d  = unsigned_q;
        err_d       = err_q;
        a_d         = a_q;
        wd_d        = wd_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        err_addr_d  = err_addr_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    size_d     = req_size;
                    write_d    = req_write;
                    unsigned_d = req_unsigned;
                    err_d      = 1'b0;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        err_d      = 1'b1;
                        err_addr_d = req_addr;
                        state_d    = RESP;
                    end else if (!req_write || (req_size != SIZE_W)) begin
                        a_d     = {req_addr[31:2], 2'b00};
                        cnt_d   = '0;
                        state_d = READ;
                    end else begin
                        a_d     = {req_addr[31:2], 2'b00};
                        wd_d    = req_wdata;
                        cnt_d   = '0;
                        state_d = WRITE;
                    end
                end
            end

            READ: begin
                if (mem_ready) begin
                    if (mem_error) begin
                        err_d      = 1'b1;
                        err_addr_d = addr_q;
                        state_d    = RESP;
                    end else if (!write_q) begin
                        load_data_d = extract_load(RD, addr_q[1:0], size_q, unsigned_q);
                        state_d     = RESP;
                    end else begin
                        wd_d    = merge_store(RD, addr_q[1:0], size_q, wdata_q);
                        cnt_d   = '0;
                        state_d = WRITE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (wait_expired) begin
                        err_d      = 1'b1;
                        err_addr_d = addr_q;
                        state_d    = RESP;
                    end
                end
            end

            WRITE: begin
                if (mem_ready) begin
                    if (mem_error) begin
                        err_d      = 1'b1;
                        err_addr_d = addr_q;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (wait_expired) begin
                        err_d      = 1'b1;
                        err_addr_d = addr_q;
                        state_d    = RESP;
                    end
                end
            end

            default: begin
                // RESP: single cycle, new requests wait for IDLE.
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            err_q       <= 1'b0;
            a_q         <= '0;
            wd_q        <= '0;
            cnt_q       <= '0;
            load_data_q <= '0;
            err_addr_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            write_q     <= write_d;
            unsigned_q  <= unsigned_d;
            err_q       <= err_d;
            a_q         <= a_d;
            wd_q        <= wd_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Outputs: stall is gated by rst so it drops in the same cycle reset rises.
    always_comb begin
        lsu_stall  = !rst && (((state_q == IDLE) && req_valid) ||
                              (state_q == READ) || (state_q == WRITE));
        WE         = (state_q == WRITE);
        load_valid = (state_q == RESP) && !err_q && !write_q;
        lsu_error  = (state_q == RESP) && err_q;
        load_data  = load_data_q;
        err_addr   = err_addr_q;
        A          = a_q;
        WD         = wd_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. Stimulus pushes hand-computed
// expectations into queues; a negedge monitor pops them whenever the DUT
// performs a read, a write, or finishes a transaction (RESP cycle).
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        lsu_stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        lsu_error;
    logic [31:0] err_addr;
    logic [31:0] A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] rd_val;
    logic        mem_ready;
    logic        mem_error;

    load_store_unit #(.TIMEOUT(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .lsu_stall    (lsu_stall),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .lsu_error    (lsu_error),
        .err_addr     (err_addr),
        .A            (A),
        .WD           (WD),
        .WE           (WE),
        .RD           (rd_val),
        .mem_ready    (mem_ready),
        .mem_error    (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic        er;
        logic [31:0] val;     // load_data when lv, err_addr when er
        int          stalls;
        int          wes;
    } resp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
    } wr_t;

    resp_t       exp_q[$];
    logic [31:0] rd_q[$];
    wr_t         wr_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int stall_run = 0;
    int we_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_resp(input logic lv, input logic er, input logic [31:0] val,
                               input int stalls, input int wes);
        resp_t e;
        e.lv = lv; e.er = er; e.val = val; e.stalls = stalls; e.wes = wes;
        exp_q.push_back(e);
    endtask

    task automatic expect_read(input logic [31:0] a);
        rd_q.push_back(a);
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] wd);
        wr_t w;
        w.a = a; w.wd = wd;
        wr_q.push_back(w);
    endtask

    // Present one request, hold it while stalled, drop it in RESP.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] ad, input logic [31:0] wd);
        int cyc;
        @(posedge clk); #1;
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = ad;
        req_wdata    = wd;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (lsu_stall && cyc < 200);
        if (lsu_stall) begin
            n_vec++;
            n_bad++;
            $display("FAIL issue_bound: lsu_stall still %b after %0d cycles, expected 0", lsu_stall, cyc);
        end
        req_valid = 1'b0;
    endtask

    // Monitor: memory accesses and transaction completions checked against the queues.
    always @(negedge clk) begin
        if (rst) begin
            stall_run = 0;
            we_run    = 0;
        end else begin
            if (lsu_stall && !WE && stall_run > 0 && mem_ready) begin
                if (rd_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_read: A=%h, expected no read", A);
                end else begin
                    check("read_A", A, rd_q.pop_front());
                end
            end
            if (WE && mem_ready) begin
                if (wr_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_write: A=%h WD=%h, expected no write", A, WD);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("write_A", A, w.a);
                    check("write_WD", WD, w.wd);
                end
            end
            if (lsu_stall) begin
                stall_run++;
                if (WE) we_run++;
            end else if (stall_run > 0) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_resp: load_valid=%b lsu_error=%b, expected none", load_valid, lsu_error);
                end else begin
                    resp_t e;
                    e = exp_q.pop_front();
                    check("resp_load_valid", 32'(load_valid), 32'(e.lv));
                    check("resp_lsu_error", 32'(lsu_error), 32'(e.er));
                    if (e.lv) check("resp_load_data", load_data, e.val);
                    if (e.er) check("resp_err_addr", err_addr, e.val);
                    check("resp_stall_cycles", 32'(stall_run), 32'(e.stalls));
                    check("resp_we_cycles", 32'(we_run), 32'(e.wes));
                    check("resp_WE_low", 32'(WE), 32'd0);
                end
                stall_run = 0;
                we_run    = 0;
            end
        end
    end

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b1;   // stall must still read 0 under reset
        req_write    = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        rd_val       = 32'h8081_8283;
        mem_ready    = 1'b1;
        mem_error    = 1'b0;

        #2;
        check("rst_lsu_stall", 32'(lsu_stall), 32'd0);
        check("rst_WE", 32'(WE), 32'd0);
        check("rst_load_valid", 32'(load_valid), 32'd0);
        check("rst_lsu_error", 32'(lsu_error), 32'd0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_err_addr", err_addr, 32'h0);
        check("rst_A", A, 32'h0);
        check("rst_WD", WD, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b0;

        // Loads from RD = 8081_8283
        expect_read(32'h0);    expect_resp(1, 0, 32'hFFFF_FF82, 2, 0); issue(0, 2'b00, 0, 32'h01, 0);
        expect_read(32'h0);    expect_resp(1, 0, 32'h0000_0082, 2, 0); issue(0, 2'b00, 1, 32'h01, 0);
        expect_read(32'h0);    expect_resp(1, 0, 32'hFFFF_FF83, 2, 0); issue(0, 2'b00, 0, 32'h00, 0);
        expect_read(32'h0);    expect_resp(1, 0, 32'hFFFF_FF80, 2, 0); issue(0, 2'b00, 0, 32'h03, 0);
        expect_read(32'h0);    expect_resp(1, 0, 32'hFFFF_8081, 2, 0); issue(0, 2'b01, 0, 32'h02, 0);
        expect_read(32'h0);    expect_resp(1, 0, 32'h0000_8283, 2, 0); issue(0, 2'b01, 1, 32'h00, 0);
        expect_read(32'h4);    expect_resp(1, 0, 32'h8081_8283, 2, 0); issue(0, 2'b10, 0, 32'h04, 0);
        expect_read(32'h1000); expect_resp(1, 0, 32'h0000_8081, 2, 0); issue(0, 2'b01, 1, 32'h1002, 0);

        // Positive sub-word values from RD = 1122_3344
        rd_val = 32'h1122_3344;
        expect_read(32'h20);   expect_resp(1, 0, 32'h0000_0022, 2, 0); issue(0, 2'b00, 0, 32'h22, 0);
        expect_read(32'h0);    expect_resp(1, 0, 32'h0000_1122, 2, 0); issue(0, 2'b01, 0, 32'h02, 0);

        // Sub-word stores (read-modify-write) and a word store
        expect_read(32'h10); expect_write(32'h10, 32'hABCD_3344); expect_resp(0, 0, 0, 3, 1);
        issue(1, 2'b01, 0, 32'h12, 32'h0000_ABCD);
        expect_read(32'h0);  expect_write(32'h0, 32'h1122_5A44);  expect_resp(0, 0, 0, 3, 1);
        issue(1, 2'b00, 0, 32'h01, 32'hFFFF_FF5A);
        expect_read(32'h0);  expect_write(32'h0, 32'h5A22_3344);  expect_resp(0, 0, 0, 3, 1);
        issue(1, 2'b00, 0, 32'h03, 32'h0000_005A);
        expect_read(32'h0);  expect_write(32'h0, 32'h1122_ABCD);  expect_resp(0, 0, 0, 3, 1);
        issue(1, 2'b01, 0, 32'h00, 32'hFFFF_ABCD);
        expect_write(32'h8, 32'hDEAD_BEEF); expect_resp(0, 0, 0, 2, 1);
        issue(1, 2'b10, 0, 32'h08, 32'hDEAD_BEEF);

        // Misaligned and illegal-size requests: one stall, no memory access
        expect_resp(0, 1, 32'h06, 1, 0); issue(0, 2'b10, 0, 32'h06, 0);
        expect_resp(0, 1, 32'h03, 1, 0); issue(1, 2'b01, 0, 32'h03, 32'h1234);
        expect_resp(0, 1, 32'h00, 1, 0); issue(0, 2'b11, 0, 32'h00, 0);

        // Word store timing out: 63 cycles of WE, then error
        mem_ready = 1'b0;
        expect_resp(0, 1, 32'h20, 64, 63); issue(1, 2'b10, 0, 32'h20, 32'hCAFE_F00D);
        mem_ready = 1'b1;

        // Memory errors: load, and sub-word store whose read errors (write skipped)
        mem_error = 1'b1;
        expect_read(32'h0C); expect_resp(0, 1, 32'h0C, 2, 0); issue(0, 2'b10, 0, 32'h0C, 0);
        expect_read(32'h04); expect_resp(0, 1, 32'h05, 2, 0); issue(1, 2'b00, 0, 32'h05, 32'h77);
        mem_error = 1'b0;

        // Reset in the middle of a WRITE wait: abandoned, no strobe, no write
        mem_ready = 1'b0;
        @(posedge clk); #1;
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h40;
        req_wdata    = 32'h1234_5678;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_WE", 32'(WE), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_WE", 32'(WE), 32'd0);
        check("mid_rst_lsu_stall", 32'(lsu_stall), 32'd0);
        check("mid_rst_err_addr", err_addr, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ready = 1'b1;
        rst       = 1'b0;

        expect_read(32'h4); expect_resp(1, 0, 32'h1122_3344, 2, 0); issue(0, 2'b10, 0, 32'h04, 0);

        repeat (3) @(posedge clk);
        #1;
        check("pending_resp", 32'(exp_q.size()), 32'd0);
        check("pending_read", 32'(rd_q.size()), 32'd0);
        check("pending_write", 32'(wr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
